// File: rtl/imm_pack.sv
// Immediate encoder: checks a 32-bit immediate against a RISC-V format, scatters it into
// instruction-word positions and merges it into a base word through a two-stage pipeline.
module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm_in,
    input  logic [2:0]       imm_sel,
    input  logic [31:0]      base_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             err_out,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic [31:0] field;
        logic [31:0] mask;
        logic        err;
    } scatter_t;

    // A format's field and mask cover exactly the destination bits; err flags unencodable values.
    function automatic scatter_t scatter(input logic [31:0] imm, input logic [2:0] sel);
        scatter_t r;
        r.field = 32'h0000_0000;
        r.mask  = 32'h0000_0000;
        r.err   = 1'b1;
        case (sel)
            3'b000: begin
                r.field[31:20] = imm[11:0];
                r.mask         = 32'hFFF0_0000;
                r.err          = !((&imm[31:11]) | ~(|imm[31:11]));
            end
            3'b001: begin
                r.field[31:25] = imm[11:5];
                r.field[11:7]  = imm[4:0];
                r.mask         = 32'hFE00_0F80;
                r.err          = !((&imm[31:11]) | ~(|imm[31:11]));
            end
            3'b010: begin
                r.field[31]    = imm[12];
                r.field[30:25] = imm[10:5];
                r.field[11:8]  = imm[4:1];
                r.field[7]     = imm[11];
                r.mask         = 32'hFE00_0F80;
                r.err          = !((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
            end
            3'b011: begin
                r.field[31:12] = imm[31:12];
                r.mask         = 32'hFFFF_F000;
                r.err          = |imm[11:0];
            end
            3'b100: begin
                r.field[31]    = imm[20];
                r.field[30:21] = imm[10:1];
                r.field[20]    = imm[11];
                r.field[19:12] = imm[19:12];
                r.mask         = 32'hFFFF_F000;
                r.err          = !((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
            end
            3'b101: begin
                // funct7 in base[31:25] survives; only the shamt bits are replaced
                r.field[24:20] = imm[4:0];
                r.mask         = 32'h01F0_0000;
                r.err          = |imm[31:5];
            end
            default: begin
                r.field = 32'h0000_0000;
                r.mask  = 32'h0000_0000;
                r.err   = 1'b1;
            end
        endcase
        return r;
    endfunction

    logic        s1_valid;
    logic [31:0] s1_field;
    logic [31:0] s1_mask;
    logic [31:0] s1_base;
    logic        s1_err;
    logic        s2_can_load;
    scatter_t    sc;

    // Stage-2 load and input readiness derived from the output handshake.
    always_comb begin
        s2_can_load = !out_valid | out_ready;
        in_ready    = !s1_valid | s2_can_load;
        sc          = scatter(imm_in, imm_sel);
    end

    // Pipeline stages and saturating delivery counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_field  <= 32'h0000_0000;
            s1_mask   <= 32'h0000_0000;
            s1_base   <= 32'h0000_0000;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            instr_out <= 32'h0000_0000;
            err_out   <= 1'b0;
            word_cnt  <= {CNT_W{1'b0}};
            err_cnt   <= {CNT_W{1'b0}};
        end else begin
            if (s2_can_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    instr_out <= (s1_base & ~s1_mask) | s1_field;
                    err_out   <= s1_err;
                end else begin
                    instr_out <= instr_out;
                    err_out   <= err_out;
                end
            end else begin
                out_valid <= out_valid;
            end

            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_field <= sc.field;
                    s1_mask  <= sc.mask;
                    s1_base  <= base_in;
                    s1_err   <= sc.err;
                end else begin
                    s1_field <= s1_field;
                end
            end else begin
                s1_valid <= s1_valid;
            end

            if (out_valid && out_ready) begin
                if (word_cnt != {CNT_W{1'b1}}) begin
                    word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    word_cnt <= word_cnt;
                end
                if (err_out && (err_cnt != {CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    err_cnt <= err_cnt;
                end
            end else begin
                word_cnt <= word_cnt;
            end
        end
    end

endmodule
